alu_issue_ctrl: RTL and testbench

Sequential issue controller on the master side of the 16-bit ADD_SUB ALU interface.
- Accepts host commands over a valid/ready handshake and holds a 4-entry register file.
- Drives the ALU operand and FuncCode inputs, captures C/OverflowFlag, writes results back and returns a response.
- Sits between the host/testbench command port and the combinational ALU; owns FuncCode encoding and the sticky overflow status.

---
 rtl/alu_issue_ctrl_if.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 103 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Command/response handshake and ALU operand bus between the host, the issue controller and the ADD_SUB ALU.
// master = host plus ALU environment, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [1:0]            cmd_rd;
  logic [1:0]            cmd_rs1;
  logic [1:0]            cmd_rs2;
  logic [DATA_WIDTH-1:0] cmd_imm;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_overflow;
  logic                  sticky_overflow;
  logic                  clr_sticky;
  logic [DATA_WIDTH-1:0] alu_A;
  logic [DATA_WIDTH-1:0] alu_B;
  logic [3:0]            alu_FuncCode;
  logic [DATA_WIDTH-1:0] alu_C;
  logic                  alu_OverflowFlag;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output rsp_ready, clr_sticky, alu_C, alu_OverflowFlag,
    input  cmd_ready, rsp_valid, rsp_data, rsp_overflow, sticky_overflow,
    input  alu_A, alu_B, alu_FuncCode
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  rsp_ready, clr_sticky, alu_C, alu_OverflowFlag,
    output cmd_ready, rsp_valid, rsp_data, rsp_overflow, sticky_overflow,
    output alu_A, alu_B, alu_FuncCode
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller: accepts host commands, drives the combinational ADD_SUB ALU for one
// cycle, writes results into a 4-entry register file and returns a held response with sticky overflow.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            r_op;
  logic [1:0]            r_rd;
  logic [1:0]            r_rs1;
  logic [1:0]            r_rs2;
  logic [DATA_WIDTH-1:0] r_regs [4];
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_ovf;
  logic                  r_sticky;
  logic                  w_accept;

  assign bus.cmd_ready       = (r_state == S_IDLE) && !reset;
  assign w_accept            = bus.cmd_valid && bus.cmd_ready;
  assign bus.rsp_valid       = (r_state == S_RESP);
  assign bus.rsp_data        = r_rsp_data;
  assign bus.rsp_overflow    = r_rsp_ovf;
  assign bus.sticky_overflow = r_sticky;

  // Function code 1111 parks the ALU at zero result, no overflow, whenever no operation is executing.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
    bus.alu_A        = '0;
    bus.alu_B        = '0;
    bus.alu_FuncCode = 4'b1111;
    if (r_state == S_EXEC) begin
      bus.alu_A        = r_regs[r_rs1];
      bus.alu_B        = r_regs[r_rs2];
      bus.alu_FuncCode = (r_op == OP_SUB) ? 4'b0001 : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_ADD;
      r_rd       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rsp_data <= '0;
      r_rsp_ovf  <= 1'b0;
      r_sticky   <= 1'b0;
      // NOTE: the register file is cleared by reset too; a reset must leave r0..r3 reading zero.
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignments so EXEC reads operands before the same-edge write.
      if (r_state == S_EXEC && bus.alu_OverflowFlag) r_sticky <= 1'b1;
      else if (bus.clr_sticky)                       r_sticky <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= bus.cmd_op;
            r_rd  <= bus.cmd_rd;
            r_rs1 <= bus.cmd_rs1;
            r_rs2 <= bus.cmd_rs2;
            case (bus.cmd_op)
              OP_LOAD: begin
                r_regs[bus.cmd_rd] <= bus.cmd_imm;
                r_rsp_data         <= bus.cmd_imm;
                r_rsp_ovf          <= 1'b0;
                r_state            <= S_RESP;
              end
              OP_READ: begin
                r_rsp_data <= r_regs[bus.cmd_rs1];
                r_rsp_ovf  <= 1'b0;
                r_state    <= S_RESP;
              end
              default: r_state <= S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          r_regs[r_rd] <= bus.alu_C;
          r_rsp_data   <= bus.alu_C;
          r_rsp_ovf    <= bus.alu_OverflowFlag;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, multi-cycle corner sequences and
// randomized commands compared against an arithmetic reference model of the register file.
module tb_alu_issue_ctrl;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [15:0] imm;
    logic [15:0] exp_data;
    logic        exp_ovf;
    logic        exp_sticky;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] m_regs [4];
  logic        m_sticky;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DATA_WIDTH(16)) bus ();
  alu_issue_ctrl #(.DATA_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Combinational ADD_SUB ALU seen by the controller.
  logic [16:0] alu_wide;
  always_comb begin
    alu_wide             = '0;
    bus.alu_C            = '0;
    bus.alu_OverflowFlag = 1'b0;
    case (bus.alu_FuncCode)
      4'b0000: begin
        alu_wide             = {bus.alu_A[15], bus.alu_A} + {bus.alu_B[15], bus.alu_B};
        bus.alu_C            = alu_wide[15:0];
        bus.alu_OverflowFlag = alu_wide[16] ^ alu_wide[15];
      end
      4'b0001: begin
        alu_wide             = {bus.alu_A[15], bus.alu_A} - {bus.alu_B[15], bus.alu_B};
        bus.alu_C            = alu_wide[15:0];
        bus.alu_OverflowFlag = alu_wide[16] ^ alu_wide[15];
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: signed integer arithmetic, result taken modulo 2^16.
  task automatic model_op(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [15:0] imm,
                          output logic [15:0] d, output logic ovf);
    int r;
    r   = 0;
    d   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD) r = int'($signed(m_regs[rs1])) + int'($signed(m_regs[rs2]));
        else              r = int'($signed(m_regs[rs1])) - int'($signed(m_regs[rs2]));
        d   = r[15:0];
        ovf = (r > 32767) || (r < -32768);
        m_regs[rd] = d;
        if (ovf) m_sticky = 1'b1;
      end
      OP_LOAD: begin
        d = imm;
        m_regs[rd] = imm;
      end
      default: d = m_regs[rs1];
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_sticky = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [15:0] imm);
    int n;
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_imm   = imm;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", n, 0);
    check("idle_funccode", bus.alu_FuncCode, 32'hF);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [15:0] imm, input int delay,
                       output logic [15:0] d, output logic ovf);
    int n;
    issue(op, rd, rs1, rs2, imm);
    if (op == OP_ADD || op == OP_SUB) begin
      @(negedge clk);
      check("exec_funccode", bus.alu_FuncCode, (op == OP_SUB) ? 32'd1 : 32'd0);
      check("exec_alu_A", bus.alu_A, m_regs[rs1]);
      check("exec_alu_B", bus.alu_B, m_regs[rs2]);
    end
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", n, 0);
    repeat (delay) @(negedge clk);
    d   = bus.rsp_data;
    ovf = bus.rsp_overflow;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_sticky = 1'b1;
    @(posedge clk);
    #1 bus.clr_sticky = 1'b0;
    m_sticky = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [10];
    logic [15:0] d, md, held;
    logic        o, mo;
    logic [1:0]  rop, rrd, rrs1, rrs2;
    logic [15:0] rimm;

    tbl[0] = '{OP_READ, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{OP_READ, 2'd0, 2'd1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{OP_READ, 2'd0, 2'd2, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{OP_READ, 2'd0, 2'd3, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{OP_LOAD, 2'd0, 2'd0, 2'd0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    tbl[5] = '{OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b0, 1'b0};
    tbl[6] = '{OP_ADD,  2'd2, 2'd0, 2'd1, 16'h0000, 16'h8000, 1'b1, 1'b1};
    tbl[7] = '{OP_READ, 2'd0, 2'd2, 2'd0, 16'h0000, 16'h8000, 1'b0, 1'b1};
    tbl[8] = '{OP_LOAD, 2'd0, 2'd0, 2'd0, 16'h8000, 16'h8000, 1'b0, 1'b1};
    tbl[9] = '{OP_SUB,  2'd3, 2'd0, 2'd1, 16'h0000, 16'h7FFF, 1'b1, 1'b1};

    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_rd     = '0;
    bus.cmd_rs1    = '0;
    bus.cmd_rs2    = '0;
    bus.cmd_imm    = '0;
    bus.rsp_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    @(negedge clk);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_ovf", bus.rsp_overflow, 0);
    check("reset_sticky", bus.sticky_overflow, 0);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_funccode", bus.alu_FuncCode, 32'hF);
    check("reset_alu_A", bus.alu_A, 0);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 0, d, o);
      model_op(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, md, mo);
      check($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
      check($sformatf("tbl%0d_ovf", i), o, tbl[i].exp_ovf);
      check($sformatf("tbl%0d_sticky", i), bus.sticky_overflow, tbl[i].exp_sticky);
    end

    // SUB into a source register: r0 = r1 - r1, sticky stays set.
    do_op(OP_SUB, 2'd0, 2'd1, 2'd1, 16'h0, 0, d, o);
    model_op(OP_SUB, 2'd0, 2'd1, 2'd1, 16'h0, md, mo);
    check("sub_self_data", d, 16'h0000);
    check("sub_self_ovf", o, 0);
    check("sub_self_sticky", bus.sticky_overflow, 1);
    do_op(OP_READ, 2'd0, 2'd0, 2'd0, 16'h0, 0, d, o);
    check("read_r0_zero", d, 16'h0000);

    // Backpressure: response held three cycles, stray command ignored.
    model_op(OP_ADD, 2'd1, 2'd3, 2'd1, 16'h0, md, mo);
    issue(OP_ADD, 2'd1, 2'd3, 2'd1, 16'h0);
    @(negedge clk);
    @(negedge clk);
    held = bus.rsp_data;
    check("bp_first_data", held, md);
    for (int k = 0; k < 3; k++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_data", bus.rsp_data, held);
      check("bp_cmd_ready", bus.cmd_ready, 0);
      if (k == 1) begin
        bus.cmd_op    = OP_LOAD;
        bus.cmd_rd    = 2'd0;
        bus.cmd_imm   = 16'hBEEF;
        bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("bp_rsp_ovf", bus.rsp_overflow, mo);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_back_idle", bus.cmd_ready, 1);
    check("bp_rsp_dropped", bus.rsp_valid, 0);
    do_op(OP_READ, 2'd0, 2'd0, 2'd0, 16'h0, 0, d, o);
    check("bp_stray_ignored", d, m_regs[0]);

    // Set wins over clear in the same cycle; a later lone clear empties sticky.
    pulse_clr();
    check("clr_sticky_alone", bus.sticky_overflow, 0);
    do_op(OP_LOAD, 2'd0, 2'd0, 2'd0, 16'h7FFF, 0, d, o);
    model_op(OP_LOAD, 2'd0, 2'd0, 2'd0, 16'h7FFF, md, mo);
    do_op(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h0001, 0, d, o);
    model_op(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h0001, md, mo);
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 16'h0);
    @(negedge clk);
    bus.clr_sticky = 1'b1;
    @(posedge clk);
    #1 bus.clr_sticky = 1'b0;
    @(negedge clk);
    check("setwins_rsp_valid", bus.rsp_valid, 1);
    check("setwins_ovf", bus.rsp_overflow, 1);
    check("setwins_sticky", bus.sticky_overflow, 1);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    model_op(OP_ADD, 2'd2, 2'd0, 2'd1, 16'h0, md, mo);
    pulse_clr();
    check("later_clr_sticky", bus.sticky_overflow, 0);

    // Reset during EXEC aborts the ADD and clears the register file.
    do_op(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h1234, 0, d, o);
    model_op(OP_LOAD, 2'd1, 2'd0, 2'd0, 16'h1234, md, mo);
    issue(OP_ADD, 2'd1, 2'd1, 2'd1, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_funccode", bus.alu_FuncCode, 32'hF);
    check("abort_rsp_data", bus.rsp_data, 0);
    for (int r = 0; r < 4; r++) begin
      do_op(OP_READ, 2'd0, 2'(r), 2'd0, 16'h0, 0, d, o);
      check($sformatf("abort_read_r%0d", r), d, 16'h0000);
    end

    // Randomized commands against the reference model.
    for (int i = 0; i < 60; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rrd  = 2'($urandom_range(0, 3));
      rrs1 = 2'($urandom_range(0, 3));
      rrs2 = 2'($urandom_range(0, 3));
      rimm = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rimm = 16'h7FFF;
        1: rimm = 16'h8000;
        2: rimm = 16'hFFFF;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        pulse_clr();
        check("rnd_clr_sticky", bus.sticky_overflow, 0);
      end
      do_op(rop, rrd, rrs1, rrs2, rimm, int'($urandom_range(0, 2)), d, o);
      model_op(rop, rrd, rrs1, rrs2, rimm, md, mo);
      check($sformatf("rnd%0d_data", i), d, md);
      check($sformatf("rnd%0d_ovf", i), o, mo);
      check($sformatf("rnd%0d_sticky", i), bus.sticky_overflow, m_sticky);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
